// File: rtl/heap_mem.sv
// Heap storage responder: entry array, heap size tracking, swap/pop/overwrite/append writes
// and two combinational read ports.
// Optional build macro: HEAP_MEM_CHECK_EN enables the sticky illegal-operation flag on err.
module heap_mem #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          swap,
    input  logic [AW-1:0] swap_idx1,
    input  logic [AW-1:0] swap_idx2,
    input  logic [AW-1:0] read_idx1,
    input  logic [AW-1:0] read_idx2,
    output logic [DW-1:0] read_data1,
    output logic [DW-1:0] read_data2,
    output logic          read_vld1,
    output logic          read_vld2,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic [DW-1:0] set_data,
    output logic [AW:0]   size,
    output logic          full,
    output logic          empty,
    output logic          err
);

    localparam logic [AW:0] SizeOne  = (AW+1)'(1);
    localparam logic [AW:0] SizeFull = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW:0]   size_q, size_d;

    logic          swap_ok, set_ok, push_fire;
    logic [AW-1:0] last_idx, tail_idx;

    // Range checks against the live size, status decode and read ports
    always_comb begin
        swap_ok    = ({1'b0, swap_idx1} < size_q) && ({1'b0, swap_idx2} < size_q);
        set_ok     = {1'b0, set_idx} < size_q;
        full       = size_q == SizeFull;
        empty      = size_q == '0;
        size       = size_q;
        push_ready = !full && !clr && !swap && !pop && !set_en;
        push_fire  = push_valid && push_ready;
        // Only meaningful when non-empty (pop) or non-full (push)
        last_idx   = AW'(size_q - SizeOne);
        tail_idx   = AW'(size_q);
        read_data1 = mem_q[read_idx1];
        read_data2 = mem_q[read_idx2];
        read_vld1  = {1'b0, read_idx1} < size_q;
        read_vld2  = {1'b0, read_idx2} < size_q;
    end

    // Single write op per cycle, priority clr > swap > pop > set_en > push
    always_comb begin
        mem_d  = mem_q;
        size_d = size_q;
        if (clr) begin
            mem_d  = '{default: '0};
            size_d = '0;
        end else if (swap) begin
            if (swap_ok) begin
                mem_d[swap_idx1] = mem_q[swap_idx2];
                mem_d[swap_idx2] = mem_q[swap_idx1];
            end
        end else if (pop) begin
            if (!empty) begin
                // Order matters: with one entry the zeroing must win over the move
                mem_d[0]        = mem_q[last_idx];
                mem_d[last_idx] = '0;
                size_d          = size_q - SizeOne;
            end
        end else if (set_en) begin
            if (set_ok) begin
                mem_d[set_idx] = set_data;
            end
        end else if (push_fire) begin
            mem_d[tail_idx] = push_data;
            size_d          = size_q + SizeOne;
        end
    end

    // Entry array and size registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            size_q <= '0;
        end else begin
            mem_q  <= mem_d;
            size_q <= size_d;
        end
    end

`ifdef HEAP_MEM_CHECK_EN
    logic err_q, err_d, illegal;

    // Flag any request that the write logic would have to drop
    always_comb begin
        illegal = (swap && !swap_ok) || (set_en && !set_ok) || (pop && empty) ||
                  (push_valid && full) ||
                  (swap && pop) || (swap && set_en) || (pop && set_en);
        err_d   = clr ? 1'b0 : (err_q || illegal);
    end

    // Sticky error flag, cleared only by reset or clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_heap_mem.sv
// Self-checking bench for heap_mem: directed scenarios plus randomized ops against an array model.
module tb_heap_mem;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk, rst_n, clr, swap, push_valid, pop, set_en;
    logic [AW-1:0] swap_idx1, swap_idx2, read_idx1, read_idx2, set_idx;
    logic [DW-1:0] read_data1, read_data2, push_data, set_data;
    logic          read_vld1, read_vld2, push_ready, full, empty, err;
    logic [AW:0]   size;

    heap_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .swap(swap),
        .swap_idx1(swap_idx1), .swap_idx2(swap_idx2),
        .read_idx1(read_idx1), .read_idx2(read_idx2),
        .read_data1(read_data1), .read_data2(read_data2),
        .read_vld1(read_vld1), .read_vld2(read_vld2),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop(pop), .set_en(set_en), .set_idx(set_idx), .set_data(set_data),
        .size(size), .full(full), .empty(empty), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model
    int m_mem[DEPTH];
    int m_size;
    bit m_err;

    function automatic bit exp_err();
`ifdef HEAP_MEM_CHECK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_size = 0;
        m_err  = 0;
    endtask

    // Apply the architectural effect of the inputs present at a clock edge
    task automatic model_edge();
        int a, b, t;
        bit bad;
        a = int'(swap_idx1);
        b = int'(swap_idx2);
        bad = (swap && (a >= m_size || b >= m_size)) || (set_en && int'(set_idx) >= m_size) ||
              (pop && m_size == 0) || (push_valid && m_size == DEPTH) ||
              (int'(swap) + int'(pop) + int'(set_en) >= 2);
        if (clr) begin
            model_reset();
        end else begin
            if (bad) m_err = 1;
            if (swap) begin
                if (a < m_size && b < m_size) begin
                    t = m_mem[a]; m_mem[a] = m_mem[b]; m_mem[b] = t;
                end
            end else if (pop) begin
                if (m_size > 0) begin
                    m_mem[0] = m_mem[m_size-1];
                    m_mem[m_size-1] = 0;
                    m_size--;
                end
            end else if (set_en) begin
                if (int'(set_idx) < m_size) m_mem[set_idx] = int'(set_data);
            end else if (push_valid && m_size < DEPTH) begin
                m_mem[m_size] = int'(push_data);
                m_size++;
            end
        end
    endtask

    task automatic idle();
        clr = 0; swap = 0; pop = 0; set_en = 0; push_valid = 0;
        swap_idx1 = 0; swap_idx2 = 0; set_idx = 0; set_data = 0; push_data = 0;
    endtask

    // One clock: model follows the edge, requests drop on the falling edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        idle();
        read_idx1 = 0; read_idx2 = 5;
        rst_n = 0;
        model_reset();
        #12;
        checks++; if (size !== 0) begin failures++; $display("FAIL reset_size: got %0d want 0", size); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (read_data1 !== 0 || read_vld1 !== 1'b0) begin
            failures++; $display("FAIL reset_read: got %0d/%b want 0/0", read_data1, read_vld1);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_fill();
        int exp3[3];
        exp3 = '{5, 9, 3};
        for (int i = 0; i < 3; i++) begin
            push_valid = 1; push_data = DW'(exp3[i]);
            tick();
        end
        checks++; if (size !== 3) begin failures++; $display("FAIL fill_size: got %0d want 3", size); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty: got %b want 0", empty); end
        for (int i = 0; i < 3; i++) begin
            read_idx1 = AW'(i); #1;
            checks++;
            if (read_data1 !== DW'(exp3[i]) || read_vld1 !== 1'b1) begin
                failures++;
                $display("FAIL fill_mem[%0d]: got %0d/%b want %0d/1", i, read_data1, read_vld1, exp3[i]);
            end
        end
    endtask

    task automatic test_swap();
        swap = 1; swap_idx1 = 0; swap_idx2 = 1;
        tick();
        read_idx1 = 0; read_idx2 = 1; #1;
        checks++; if (read_data1 !== 9 || read_data2 !== 5) begin
            failures++; $display("FAIL swap_01: got %0d,%0d want 9,5", read_data1, read_data2);
        end
        swap = 1; swap_idx1 = 0; swap_idx2 = 7;
        tick();
        #1;
        checks++; if (read_data1 !== 9 || read_data2 !== 5 || size !== 3) begin
            failures++;
            $display("FAIL swap_oob: got %0d,%0d size %0d want 9,5 size 3", read_data1, read_data2, size);
        end
        checks++; if (err !== exp_err()) begin
            failures++; $display("FAIL swap_oob_err: got %b want %b", err, exp_err());
        end
    endtask

    task automatic test_pop();
        pop = 1;
        tick();
        read_idx1 = 0; read_idx2 = 2; #1;
        checks++; if (read_data1 !== 3 || size !== 2) begin
            failures++; $display("FAIL pop_root: got %0d size %0d want 3 size 2", read_data1, size);
        end
        checks++; if (read_data2 !== 0 || read_vld2 !== 1'b0) begin
            failures++; $display("FAIL pop_tail: got %0d/%b want 0/0", read_data2, read_vld2);
        end
        pop = 1; tick();
        pop = 1; tick();
        #1;
        checks++; if (size !== 0 || empty !== 1'b1 || read_data1 !== 0) begin
            failures++; $display("FAIL pop_drain: size %0d empty %b mem0 %0d want 0 1 0", size, empty, read_data1);
        end
        pop = 1; tick();
        checks++; if (size !== 0) begin failures++; $display("FAIL pop_empty: got %0d want 0", size); end
        checks++; if (err !== exp_err()) begin
            failures++; $display("FAIL pop_empty_err: got %b want %b", err, exp_err());
        end
    endtask

    task automatic test_full_collision();
        clr = 1; tick();
        checks++; if (size !== 0 || err !== 1'b0) begin
            failures++; $display("FAIL clr: size %0d err %b want 0 0", size, err);
        end
        for (int i = 0; i < DEPTH; i++) begin
            push_valid = 1; push_data = DW'(i * 3 + 1);
            tick();
        end
        checks++; if (full !== 1'b1 || push_ready !== 1'b0 || size !== 16) begin
            failures++; $display("FAIL full: full %b ready %b size %0d want 1 0 16", full, push_ready, size);
        end
        push_valid = 1; push_data = 8'hAA; #1;
        checks++; if (push_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready: got %b want 0", push_ready);
        end
        tick();
        read_idx1 = 15; #1;
        checks++; if (size !== 16 || read_data1 !== 46) begin
            failures++; $display("FAIL push_17: size %0d mem15 %0d want 16 46", size, read_data1);
        end
        pop = 1; tick();
        swap = 1; swap_idx1 = 0; swap_idx2 = 1; push_valid = 1; push_data = 8'h55; #1;
        checks++; if (push_ready !== 1'b0) begin
            failures++; $display("FAIL swap_push_ready: got %b want 0", push_ready);
        end
        tick();
        read_idx1 = 0; read_idx2 = 1; #1;
        checks++; if (size !== 15 || read_data1 !== DW'(m_mem[0]) || read_data2 !== DW'(m_mem[1])) begin
            failures++;
            $display("FAIL swap_push: size %0d data %0d,%0d want 15 %0d,%0d",
                     size, read_data1, read_data2, m_mem[0], m_mem[1]);
        end
    endtask

    task automatic test_set_read();
        set_en = 1; set_idx = 1; set_data = 8'hFF;
        tick();
        read_idx1 = 1; read_idx2 = AW'(m_size); #1;
        checks++; if (read_data1 !== 8'hFF || read_vld1 !== 1'b1) begin
            failures++; $display("FAIL set_read: got %0h/%b want ff/1", read_data1, read_vld1);
        end
        checks++; if (read_vld2 !== 1'b0) begin
            failures++; $display("FAIL read_vld_size: got %b want 0", read_vld2);
        end
        set_en = 1; set_idx = 15; set_data = 8'h77;
        tick();
        read_idx2 = 15; #1;
        checks++; if (read_data2 !== DW'(m_mem[15])) begin
            failures++; $display("FAIL set_oob: got %0d want %0d", read_data2, m_mem[15]);
        end
    endtask

    task automatic test_async_reset();
        swap = 1; swap_idx1 = 0; swap_idx2 = 2;
        read_idx1 = 0; read_idx2 = 2;
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++; if (size !== 0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL arst_status: size %0d empty %b full %b err %b want 0 1 0 0",
                                 size, empty, full, err);
        end
        checks++; if (read_data1 !== 0 || read_data2 !== 0) begin
            failures++; $display("FAIL arst_data: got %0d,%0d want 0,0", read_data1, read_data2);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1;
        #1;
        checks++; if (size !== 0 || read_data1 !== 0 || read_data2 !== 0) begin
            failures++; $display("FAIL arst_hold: size %0d data %0d,%0d want 0 0,0", size, read_data1, read_data2);
        end
    endtask

    task automatic test_random();
        int r;
        bit want_ready;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            r = $urandom_range(0, 99);
            if (r < 2) clr = 1;
            else if (r < 17) swap = 1;
            else if (r < 27) pop = 1;
            else if (r < 39) set_en = 1;
            else push_valid = 1;
            if ($urandom_range(0, 19) == 0) push_valid = 1;
            if ($urandom_range(0, 29) == 0) pop = 1;
            swap_idx1 = AW'($urandom_range(0, 15));
            swap_idx2 = AW'($urandom_range(0, 15));
            set_idx   = AW'($urandom_range(0, 15));
            set_data  = DW'($urandom);
            push_data = DW'($urandom);
            read_idx1 = AW'($urandom_range(0, 15));
            read_idx2 = AW'($urandom_range(0, 15));
            #1;
            want_ready = (m_size != DEPTH) && !clr && !swap && !pop && !set_en;
            checks++;
            if (read_data1 !== DW'(m_mem[read_idx1]) || read_data2 !== DW'(m_mem[read_idx2]) ||
                read_vld1 !== (int'(read_idx1) < m_size) || read_vld2 !== (int'(read_idx2) < m_size)) begin
                failures++;
                $display("FAIL rnd_read c%0d: got %0d/%b %0d/%b want %0d/%b %0d/%b", cyc,
                         read_data1, read_vld1, read_data2, read_vld2,
                         m_mem[read_idx1], int'(read_idx1) < m_size,
                         m_mem[read_idx2], int'(read_idx2) < m_size);
            end
            checks++;
            if (size !== (AW+1)'(m_size) || full !== (m_size == DEPTH) || empty !== (m_size == 0) ||
                push_ready !== want_ready || err !== exp_err()) begin
                failures++;
                $display("FAIL rnd_status c%0d: size %0d full %b empty %b rdy %b err %b want %0d %b %b %b %b",
                         cyc, size, full, empty, push_ready, err,
                         m_size, m_size == DEPTH, m_size == 0, want_ready, exp_err());
            end
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        rst_n = 1;
        idle();
        read_idx1 = 0; read_idx2 = 0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_swap();
        test_pop();
        test_full_collision();
        test_set_read();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

endmodule
